biquad_mac_seq: RTL and testbench

- Sequences one shared sign-magnitude multiplier (a: COEFWIDTH-1 bits, b: DATAWIDTH-1 bits, r: DATAWIDTH+COEFWIDTH-2 bits, combinational) over the five products of a Direct Form I biquad.
- Holds the x/y history and accumulates signed products.
- Emits one saturated output sample per accepted input sample.
- Sits between the sample stream and the multiplier instance.

---
 rtl/biquad_mac_seq.sv | 199 +++++++++++++++++++
 tb/tb_biquad_mac_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/biquad_mac_seq.sv
// Direct Form I biquad sequencer: time-shares one external sign-magnitude multiplier over five taps.
// Define MUL_PIPE_EN to register mul_r inside the block (adds a DRAIN state, one more cycle per sample).
module biquad_mac_seq #(
  parameter int DATAWIDTH = 12,
  parameter int COEFWIDTH = 16
) (
  input  logic                           clk,
  input  logic                           nreset,
  input  logic                           clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATAWIDTH-1:0]           din,
  input  logic [COEFWIDTH-1:0]           b0,
  input  logic [COEFWIDTH-1:0]           b1,
  input  logic [COEFWIDTH-1:0]           b2,
  input  logic [COEFWIDTH-1:0]           a1,
  input  logic [COEFWIDTH-1:0]           a2,
  output logic                           out_valid,
  output logic [DATAWIDTH-1:0]           dout,
  output logic                           busy,
  output logic [COEFWIDTH-2:0]           mul_a,
  output logic [DATAWIDTH-2:0]           mul_b,
  input  logic [DATAWIDTH+COEFWIDTH-3:0] mul_r
);

  localparam int PW   = DATAWIDTH + COEFWIDTH - 2;
  localparam int ACCW = DATAWIDTH + COEFWIDTH + 2;
  localparam int FRAC = COEFWIDTH - 2;
  localparam logic signed [ACCW-1:0] YMAX = ACCW'((2 ** (DATAWIDTH - 1)) - 1);
  localparam logic signed [ACCW-1:0] YMIN = -YMAX;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MAC   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
`ifdef MUL_PIPE_EN
  localparam logic [1:0] MAC_EXIT = DRAIN;
`else
  localparam logic [1:0] MAC_EXIT = DONE;
`endif

  // Magnitude helpers: the most negative code clamps to the largest positive magnitude.
  function automatic logic [COEFWIDTH-2:0] coef_mag(input logic [COEFWIDTH-1:0] c);
    logic [COEFWIDTH-1:0] n;
    n = -c;
    if (!c[COEFWIDTH-1]) coef_mag = c[COEFWIDTH-2:0];
    else if (c[COEFWIDTH-2:0] == {(COEFWIDTH-1){1'b0}}) coef_mag = {(COEFWIDTH-1){1'b1}};
    else coef_mag = n[COEFWIDTH-2:0];
  endfunction

  function automatic logic [DATAWIDTH-2:0] data_mag(input logic [DATAWIDTH-1:0] d);
    logic [DATAWIDTH-1:0] n;
    n = -d;
    if (!d[DATAWIDTH-1]) data_mag = d[DATAWIDTH-2:0];
    else if (d[DATAWIDTH-2:0] == {(DATAWIDTH-1){1'b0}}) data_mag = {(DATAWIDTH-1){1'b1}};
    else data_mag = n[DATAWIDTH-2:0];
  endfunction

  function automatic logic signed [ACCW-1:0] term(input logic [PW-1:0] p, input logic neg);
    logic signed [ACCW-1:0] e;
    e = $signed({{(ACCW-PW){1'b0}}, p});
    term = neg ? -e : e;
  endfunction

  // Arithmetic shift floors toward -inf; clip is symmetric so -2^(W-1) never appears.
  function automatic logic [DATAWIDTH-1:0] sat(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] s;
    s = a >>> FRAC;
    if (s > YMAX) sat = YMAX[DATAWIDTH-1:0];
    else if (s < YMIN) sat = YMIN[DATAWIDTH-1:0];
    else sat = s[DATAWIDTH-1:0];
  endfunction

  logic [1:0]             state_r;
  logic [2:0]             tap_r;
  logic [DATAWIDTH-1:0]   x0_r, x1_r, x2_r, y1_r, y2_r, dout_r;
  logic signed [ACCW-1:0] acc_r;
  logic signed [ACCW-1:0] add_s;
  logic [COEFWIDTH-1:0]   coef_s;
  logic [DATAWIDTH-1:0]   data_s;
  logic                   neg_s;
  logic                   in_mac_s;
  logic [DATAWIDTH-1:0]   sat_s;

  assign in_mac_s = (state_r == MAC);
  assign sat_s    = sat(acc_r);

  // Tap operand selection and product sign.
  always_comb begin
    coef_s = {COEFWIDTH{1'b0}};
    data_s = {DATAWIDTH{1'b0}};
    case (tap_r)
      3'd0: begin coef_s = b0; data_s = x0_r; end
      3'd1: begin coef_s = b1; data_s = x1_r; end
      3'd2: begin coef_s = b2; data_s = x2_r; end
      3'd3: begin coef_s = a1; data_s = y1_r; end
      3'd4: begin coef_s = a2; data_s = y2_r; end
      default: begin coef_s = {COEFWIDTH{1'b0}}; data_s = {DATAWIDTH{1'b0}}; end
    endcase
    neg_s = coef_s[COEFWIDTH-1] ^ data_s[DATAWIDTH-1] ^ (tap_r >= 3'd3);
  end

  // Multiplier operands are driven only while a tap is being presented.
  always_comb begin
    if (in_mac_s) begin
      mul_a = coef_mag(coef_s);
      mul_b = data_mag(data_s);
    end else begin
      mul_a = {(COEFWIDTH-1){1'b0}};
      mul_b = {(DATAWIDTH-1){1'b0}};
    end
  end

`ifdef MUL_PIPE_EN
  logic [PW-1:0] p_r;
  logic          pneg_r;
  logic          pv_r;

  // Product pipeline stage; the tap's sign travels with its product.
  always_ff @(posedge clk) begin
    if (!nreset || clear) begin
      p_r    <= {PW{1'b0}};
      pneg_r <= 1'b0;
      pv_r   <= 1'b0;
    end else begin
      p_r    <= mul_r;
      pneg_r <= neg_s;
      pv_r   <= in_mac_s;
    end
  end

  assign add_s = pv_r ? term(p_r, pneg_r) : {ACCW{1'b0}};
`else
  assign add_s = in_mac_s ? term(mul_r, neg_s) : {ACCW{1'b0}};
`endif

  // Sequencer, accumulator and x/y history.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_r <= IDLE;
      tap_r   <= 3'd0;
      acc_r   <= {ACCW{1'b0}};
      x0_r    <= {DATAWIDTH{1'b0}};
      x1_r    <= {DATAWIDTH{1'b0}};
      x2_r    <= {DATAWIDTH{1'b0}};
      y1_r    <= {DATAWIDTH{1'b0}};
      y2_r    <= {DATAWIDTH{1'b0}};
      dout_r  <= {DATAWIDTH{1'b0}};
    end else if (clear) begin
      state_r <= IDLE;
      tap_r   <= 3'd0;
      acc_r   <= {ACCW{1'b0}};
      x1_r    <= {DATAWIDTH{1'b0}};
      x2_r    <= {DATAWIDTH{1'b0}};
      y1_r    <= {DATAWIDTH{1'b0}};
      y2_r    <= {DATAWIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            x0_r    <= din;
            acc_r   <= {ACCW{1'b0}};
            tap_r   <= 3'd0;
            state_r <= MAC;
          end
        end
        MAC: begin
          acc_r <= acc_r + add_s;
          if (tap_r == 3'd4) begin
            tap_r   <= 3'd0;
            state_r <= MAC_EXIT;
          end else begin
            tap_r <= tap_r + 3'd1;
          end
        end
        DRAIN: begin
          acc_r   <= acc_r + add_s;
          state_r <= DONE;
        end
        DONE: begin
          x2_r    <= x1_r;
          x1_r    <= x0_r;
          y2_r    <= y1_r;
          y1_r    <= sat_s;
          dout_r  <= sat_s;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // A clear or reset in DONE suppresses the pulse, so the output is presented from DONE directly.
  assign busy      = (state_r != IDLE);
  assign in_ready  = nreset && !clear && (state_r == IDLE);
  assign out_valid = nreset && !clear && (state_r == DONE);
  assign dout      = out_valid ? sat_s : dout_r;

endmodule

// File: tb/tb_biquad_mac_seq.sv
// Directed bench for biquad_mac_seq; the bench supplies the external multiplier.
module tb_biquad_mac_seq;
  localparam int DW = 12;
  localparam int CW = 16;
  localparam int PW = DW + CW - 2;
`ifdef MUL_PIPE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 6;
`endif

  logic          clk = 1'b0;
  logic          nreset, clear, in_valid;
  logic          in_ready, out_valid, busy;
  logic [DW-1:0] din, dout;
  logic [CW-1:0] b0, b1, b2, a1, a2;
  logic [CW-2:0] mul_a;
  logic [DW-2:0] mul_b;
  logic [PW-1:0] mul_r;

  int n_assert = 0;
  int n_fail   = 0;
  int acc_cyc[$];
  int outs[$];

  always #5 clk = ~clk;

  assign mul_r = PW'(mul_a) * PW'(mul_b);

  biquad_mac_seq #(.DATAWIDTH(DW), .COEFWIDTH(CW)) dut (
    .clk(clk), .nreset(nreset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
    .out_valid(out_valid), .dout(dout), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offers one sample from IDLE, captures tap-0 operands, output and its latency in cycles.
  task automatic run(input logic [DW-1:0] x, output logic [DW-1:0] y, output int lat,
                     output logic [CW-2:0] ma, output logic [DW-2:0] mb);
    chk("ready_before_sample", in_ready, 1);
    in_valid = 1'b1;
    din      = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    ma  = mul_a;
    mb  = mul_b;
    lat = 0;
    y   = {DW{1'bx}};
    for (int k = 1; k <= 12; k++) begin
      if (out_valid) begin
        lat = k;
        y   = dout;
        break;
      end
      @(posedge clk); #2;
    end
    @(posedge clk); #2;
    chk("ready_after_output", in_ready, 1);
  endtask

  // Clear in IDLE with a competing in_valid; the sample must be refused.
  task automatic do_clear();
    clear    = 1'b1;
    in_valid = 1'b1;
    din      = 12'd5;
    #1;
    chk("clear_blocks_ready", in_ready, 0);
    @(posedge clk); #2;
    clear    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("clear_no_accept", busy, 0);
  endtask

  initial begin
    logic [DW-1:0] y;
    int            lat;
    logic [CW-2:0] ma;
    logic [DW-2:0] mb;
    logic          took;
    int            nxt;
    int            pulses;

    nreset = 1'b0; clear = 1'b0; in_valid = 1'b0; din = 12'd0;
    b0 = 16'd0; b1 = 16'd0; b2 = 16'd0; a1 = 16'd0; a2 = 16'd0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout", $signed(dout), 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mul_a", mul_a, 0);
    nreset = 1'b1;
    #1;
    chk("rst_release_ready", in_ready, 1);

    // Passthrough
    b0 = 16'd16384;
    run(12'd100, y, lat, ma, mb);
    chk("pass_latency", lat, LAT);
    chk("pass_dout", $signed(y), 100);
    chk("pass_mul_a", ma, 16384);
    chk("pass_mul_b", mb, 100);

    // First-order feedback, y = x + 0.5*y1
    a1 = 16'hE000;
    do_clear();
    run(12'd1000, y, lat, ma, mb); chk("fb_y0", $signed(y), 1000);
    run(12'd0, y, lat, ma, mb);    chk("fb_y1", $signed(y), 500);
    run(12'd0, y, lat, ma, mb);    chk("fb_y2", $signed(y), 250);
    run(12'd0, y, lat, ma, mb);    chk("fb_y3", $signed(y), 125);
    run(12'd0, y, lat, ma, mb);    chk("fb_floor", $signed(y), 62);

    // Saturation and most-negative clamp
    a1 = 16'd0;
    b0 = 16'd32767;
    do_clear();
    run(12'd2047, y, lat, ma, mb);
    chk("sat_pos", $signed(y), 2047);
    chk("sat_mul_a", ma, 32767);
    b0 = 16'd16384;
    do_clear();
    run(12'h800, y, lat, ma, mb);
    chk("clamp_mul_b", mb, 2047);
    chk("clamp_dout", $signed(y), -2047);

    // Abort mid-MAC: history cleared, dout held
    a1 = 16'hE000;
    do_clear();
    run(12'd1000, y, lat, ma, mb);
    chk("abort_setup", $signed(y), 1000);
    in_valid = 1'b1;
    din      = 12'd400;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear = 1'b1;
    #1;
    chk("abort_busy_tap2", busy, 1);
    chk("abort_mul_b_tap2", mul_b, 0);
    @(posedge clk); #1;
    clear = 1'b0;
    #1;
    chk("abort_idle", busy, 0);
    chk("abort_dout_held", $signed(dout), 1000);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) pulses++;
      @(posedge clk); #2;
    end
    chk("abort_no_pulse", pulses, 0);
    run(12'd400, y, lat, ma, mb);
    chk("abort_history_zero", $signed(y), 400);

    // Handshake with in_valid held high
    a1 = 16'd0;
    do_clear();
    din      = 12'd1;
    in_valid = 1'b1;
    nxt      = 1;
    for (int c = 0; c < 30; c++) begin
      took = in_valid && in_ready;
      if (out_valid) outs.push_back(int'($signed(dout)));
      if (took) acc_cyc.push_back(c);
      @(posedge clk); #1;
      if (took) begin
        nxt++;
        if (nxt > 3) in_valid = 1'b0;
        else din = 12'(nxt);
      end
      #1;
    end
    in_valid = 1'b0;
    chk("hs_accept_count", acc_cyc.size(), 3);
    chk("hs_output_count", outs.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("hs_accept_cycle", (i < acc_cyc.size()) ? acc_cyc[i] : -1, i * (LAT + 1));
      chk("hs_dout", (i < outs.size()) ? outs[i] : -99, i + 1);
    end

    // Reset during DONE
    do_clear();
    in_valid = 1'b1;
    din      = 12'd50;
    @(posedge clk); #2;
    in_valid = 1'b0;
    for (int k = 0; k < 12 && !out_valid; k++) begin
      @(posedge clk); #2;
    end
    chk("rstmid_reach_done", out_valid, 1);
    nreset = 1'b0;
    #1;
    chk("rstmid_pulse_gone", out_valid, 0);
    chk("rstmid_ready_low", in_ready, 0);
    @(posedge clk); #2;
    chk("rstmid_dout", $signed(dout), 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_ready_in_rst", in_ready, 0);
    nreset = 1'b1;
    #1;
    chk("rstmid_ready_after", in_ready, 1);
    run(12'd7, y, lat, ma, mb);
    chk("rstmid_next_sample", $signed(y), 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
